// File: rtl/pc_fetch_unit_24.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit_24
//  Description : Program-counter and instruction-fetch sequencer for the
//                24-bit CPU. Holds the PC and exports PC+PC_INC to input 0 of
//                the external next-PC mux. Loads the mux output on every
//                instruction handoff to decode. Runs a req/ack fetch
//                handshake with instruction memory and a valid/ready issue
//                handshake with decode.
//  Optional    : FETCH_TIMEOUT_EN - builds a fetch watchdog. After
//                TIMEOUT_CYCLES un-acked FETCH cycles it sets the sticky
//                FetchErr flag, restores RESET_PC and returns to IDLE.
//  Ports       : Clock, ResetN (async, active-low)
//                Start, Halt          - sequencer control (levels)
//                NextPC / PCPlus1     - next-PC mux output / input 0
//                PC                   - current program counter
//                MemReq/MemAddr/MemAck/MemData - instruction memory port
//                Instr/InstrValid/InstrReady   - decode issue port
//                FetchErr             - sticky watchdog error
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit_24 #(
    parameter logic [23:0] RESET_PC       = 24'h000000,
    parameter logic [23:0] PC_INC         = 24'd1,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic        Start,
    input  logic        Halt,
    input  logic [23:0] NextPC,
    output logic [23:0] PCPlus1,
    output logic [23:0] PC,
    output logic        MemReq,
    output logic [23:0] MemAddr,
    input  logic        MemAck,
    input  logic [23:0] MemData,
    output logic [23:0] Instr,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic        FetchErr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic   capture;     // memory ack accepted this cycle
    logic   handoff;     // decode accepted Instr this cycle
    logic   abort;       // watchdog fired this cycle
    logic   timeout_hit; // last permitted wait cycle with no ack

    // ------------------------------------------------------------------
    // Fetch watchdog
    // ------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             fetch_err_q;

    // The counter holds the number of completed un-acked FETCH cycles. It
    // is zero whenever FETCH is entered because it idles at zero elsewhere.
    assign timeout_hit = (wait_cnt == CNT_LAST);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            wait_cnt    <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            if (state_q != FETCH || MemAck || abort) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (abort) begin
                fetch_err_q <= 1'b1;
            end
        end
    end

    assign FetchErr = fetch_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_hit        = 1'b0;
    assign FetchErr           = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and event decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        handoff = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                // Halt takes priority over Start
                if (Start && !Halt) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // An ack coinciding with the watchdog limit still wins
                if (MemAck) begin
                    capture = 1'b1;
                    state_d = ISSUE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (InstrReady) begin
                    handoff = 1'b1;
                    state_d = Halt ? IDLE : FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC and instruction registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            PC <= RESET_PC;
        end else if (abort) begin
            PC <= RESET_PC;
        end else if (handoff) begin
            PC <= NextPC;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            Instr <= '0;
        end else if (capture) begin
            Instr <= MemData;
        end
    end

    // ------------------------------------------------------------------
    // Decoded outputs
    // ------------------------------------------------------------------
    assign PCPlus1    = PC + PC_INC;   // 24-bit, wraps naturally
    assign MemAddr    = PC;
    assign MemReq     = (state_q == FETCH);
    assign InstrValid = (state_q == ISSUE);

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit_24.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_unit_24
//  Description : Self-checking bench for pc_fetch_unit_24. A table of
//                instruction records drives fetch/issue sequences. Fetched
//                words are queued when memory acks and compared when decode
//                takes them. Hand-written sequences cover halt, watchdog
//                and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit_24;

    logic        clk;
    logic        ResetN;
    logic        Start;
    logic        Halt;
    logic [23:0] NextPC;
    logic [23:0] PCPlus1;
    logic [23:0] PC;
    logic        MemReq;
    logic [23:0] MemAddr;
    logic        MemAck;
    logic [23:0] MemData;
    logic [23:0] Instr;
    logic        InstrValid;
    logic        InstrReady;
    logic        FetchErr;

    // External next-PC mux: input 0 = PCPlus1, input 1 = branch target
    logic        use_branch;
    logic [23:0] branch_target;
    assign NextPC = use_branch ? branch_target : PCPlus1;

    int checks = 0;
    int errors = 0;
    logic [23:0] sb_q[$];

    pc_fetch_unit_24 #(
        .RESET_PC       (24'h000000),
        .PC_INC         (24'd1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .Clock      (clk),
        .ResetN     (ResetN),
        .Start      (Start),
        .Halt       (Halt),
        .NextPC     (NextPC),
        .PCPlus1    (PCPlus1),
        .PC         (PC),
        .MemReq     (MemReq),
        .MemAddr    (MemAddr),
        .MemAck     (MemAck),
        .MemData    (MemData),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .FetchErr   (FetchErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] addr;      // expected MemAddr/PC during the fetch
        logic [23:0] plus1;     // expected PCPlus1 during the fetch
        int          ack_wait;  // cycles memory stalls before acking
        logic [23:0] data;      // instruction word returned
        int          delay;     // ISSUE cycles with InstrReady low
        logic        ub;        // mux select at handoff
        logic [23:0] tgt;       // branch target
        logic [23:0] next;      // expected PC after handoff
    } vec_t;

    vec_t vecs[4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: a handoff happens at the next rising edge when valid and
    // ready are both high; compare the issued word with the oldest fetch.
    always @(negedge clk) begin
        if (ResetN && InstrValid && InstrReady) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL handoff: got %h expected no instruction", Instr);
            end else begin
                logic [23:0] e;
                e = sb_q.pop_front();
                if (Instr !== e) begin
                    errors++;
                    $display("FAIL handoff: got %h expected %h", Instr, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vecs[0] = '{24'h000001, 24'h000002, 0, 24'h123456, 3, 1'b0, 24'h000000, 24'h000002};
        vecs[1] = '{24'h000002, 24'h000003, 2, 24'h0A0A0A, 0, 1'b1, 24'h000020, 24'h000020};
        vecs[2] = '{24'h000020, 24'h000021, 0, 24'h555555, 1, 1'b1, 24'hFFFFFF, 24'hFFFFFF};
        vecs[3] = '{24'hFFFFFF, 24'h000000, 1, 24'hABCDEF, 0, 1'b0, 24'h000000, 24'h000000};

        ResetN = 1'b0; Start = 1'b0; Halt = 1'b0; MemAck = 1'b0;
        MemData = '0; InstrReady = 1'b0; use_branch = 1'b0; branch_target = '0;

        // ---------------- reset state ----------------
        step(); step();
        chk("rst_pc",      PC,         24'h000000);
        chk("rst_instr",   Instr,      24'h000000);
        chk("rst_memreq",  {23'd0, MemReq},     24'd0);
        chk("rst_valid",   {23'd0, InstrValid}, 24'd0);
        chk("rst_err",     {23'd0, FetchErr},   24'd0);
        chk("rst_plus1",   PCPlus1,    24'h000001);
        ResetN = 1'b1;
        step();
        chk("idle_memreq", {23'd0, MemReq}, 24'd0);

        // ---------------- first fetch ----------------
        Start = 1'b1; InstrReady = 1'b1;
        step();
        chk("t1_memreq",  {23'd0, MemReq}, 24'd1);
        chk("t1_addr",    MemAddr,  24'h000000);
        MemAck = 1'b1; MemData = 24'h00ABCD; sb_q.push_back(24'h00ABCD);
        step();
        MemAck = 1'b0;
        chk("t1_valid",   {23'd0, InstrValid}, 24'd1);
        chk("t1_instr",   Instr,    24'h00ABCD);
        chk("t1_memreq0", {23'd0, MemReq}, 24'd0);
        step();
        Start = 1'b0;
        chk("t1_next_addr", MemAddr, 24'h000001);
        chk("t1_memreq1",   {23'd0, MemReq}, 24'd1);

        // ---------------- table-driven instruction stream ----------------
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("v%0d_addr", i),  MemAddr, vecs[i].addr);
            chk($sformatf("v%0d_plus1", i), PCPlus1, vecs[i].plus1);
            for (int w = 0; w < vecs[i].ack_wait; w++) begin
                step();
                chk($sformatf("v%0d_wait_req", i),  {23'd0, MemReq}, 24'd1);
                chk($sformatf("v%0d_wait_addr", i), MemAddr, vecs[i].addr);
            end
            MemAck = 1'b1; MemData = vecs[i].data; sb_q.push_back(vecs[i].data);
            InstrReady = (vecs[i].delay == 0);
            use_branch = vecs[i].ub; branch_target = vecs[i].tgt;
            step();
            MemAck = 1'b0; MemData = 24'h0;
            chk($sformatf("v%0d_valid", i), {23'd0, InstrValid}, 24'd1);
            chk($sformatf("v%0d_instr", i), Instr, vecs[i].data);
            for (int d = 0; d < vecs[i].delay; d++) begin
                step();
                chk($sformatf("v%0d_hold_valid", i), {23'd0, InstrValid}, 24'd1);
                chk($sformatf("v%0d_hold_instr", i), Instr, vecs[i].data);
                chk($sformatf("v%0d_hold_pc", i),    PC, vecs[i].addr);
                chk($sformatf("v%0d_hold_req", i),   {23'd0, MemReq}, 24'd0);
            end
            InstrReady = 1'b1;
            step();
            chk($sformatf("v%0d_next_pc", i),  PC, vecs[i].next);
            chk($sformatf("v%0d_next_req", i), {23'd0, MemReq}, 24'd1);
        end
        use_branch = 1'b0;

        // ---------------- halt during fetch ----------------
        Halt = 1'b1;
        step();
        chk("halt_fetch_req", {23'd0, MemReq}, 24'd1);
        MemAck = 1'b1; MemData = 24'h0F0F0F; sb_q.push_back(24'h0F0F0F);
        step();
        MemAck = 1'b0;
        chk("halt_issue_valid", {23'd0, InstrValid}, 24'd1);
        Start = 1'b1;
        step();
        chk("halt_idle_req",   {23'd0, MemReq}, 24'd0);
        chk("halt_idle_valid", {23'd0, InstrValid}, 24'd0);
        chk("halt_pc",         PC, 24'h000001);
        MemAck = 1'b1; MemData = 24'h777777;
        InstrReady = 1'b1;
        repeat (3) step();
        chk("halt_start_ignored", {23'd0, MemReq}, 24'd0);
        chk("idle_ack_ignored",   Instr, 24'h0F0F0F);
        MemAck = 1'b0; MemData = 24'h0;
        Halt = 1'b0;
        step();
        Start = 1'b0;
        chk("resume_req",  {23'd0, MemReq}, 24'd1);
        chk("resume_addr", MemAddr, 24'h000001);

        // ---------------- no ack: watchdog / indefinite wait ----------------
`ifdef FETCH_TIMEOUT_EN
        repeat (15) step();
        chk("to_pre_req", {23'd0, MemReq},   24'd1);
        chk("to_pre_err", {23'd0, FetchErr}, 24'd0);
        step();
        chk("to_req",  {23'd0, MemReq},   24'd0);
        chk("to_err",  {23'd0, FetchErr}, 24'd1);
        chk("to_pc",   PC, 24'h000000);
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("to_sticky_err", {23'd0, FetchErr}, 24'd1);
`else
        repeat (20) step();
        chk("nto_req", {23'd0, MemReq},   24'd1);
        chk("nto_err", {23'd0, FetchErr}, 24'd0);
        chk("nto_pc",  PC, 24'h000001);
`endif

        // ---------------- asynchronous reset mid-ISSUE ----------------
        MemAck = 1'b1; MemData = 24'h3C3C3C; sb_q.push_back(24'h3C3C3C);
        InstrReady = 1'b0;
        step();
        MemAck = 1'b0;
        chk("ar_valid_pre", {23'd0, InstrValid}, 24'd1);
        #2;
        ResetN = 1'b0;
        #1;
        chk("ar_valid", {23'd0, InstrValid}, 24'd0);
        chk("ar_instr", Instr, 24'h000000);
        chk("ar_pc",    PC, 24'h000000);
        chk("ar_req",   {23'd0, MemReq}, 24'd0);
        chk("ar_err",   {23'd0, FetchErr}, 24'd0);
        sb_q.delete();
        step();
        ResetN = 1'b1;
        step();
        chk("sb_empty", 24'(sb_q.size()), 24'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
